conv3x3_relu_pipe: RTL and testbench

//  Consumes the 3x3 window stream of the line-buffer stage (9 signed 9-bit pixels, flat packed) and

---
 rtl/conv3x3_relu_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_conv3x3_relu_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_relu_pipe.sv
// 3x3 convolution + bias, arithmetic shift, ReLU and saturation over a window stream.
// Kernel loads through a serial config port; four register stages give a fixed 3-cycle latency.
module conv3x3_relu_pipe #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned WGT_W = 8,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned OUT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  input  logic [15:0]                cfg_data,
  output logic                       cfg_done,
  input  logic                       win_valid,
  input  logic [80:0]                win_flat,
  input  logic [$clog2(IMG_W)-1:0]   win_x,
  input  logic [$clog2(IMG_H)-1:0]   win_y,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_pixel,
  output logic [$clog2(IMG_W)-1:0]   out_x,
  output logic [$clog2(IMG_H)-1:0]   out_y,
  output logic                       frame_done,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned XW     = $clog2(IMG_W);
  localparam int unsigned YW     = $clog2(IMG_H);
  localparam int unsigned TAPS   = 9;
  localparam int unsigned PIX_W  = 9;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned ROW_W  = 19;
  localparam int unsigned ACC_W  = 22;
  localparam int unsigned BIAS_W = 16;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** OUT_W) - 1);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e                    state_q,   state_d;
  logic [3:0]                cfg_idx_q, cfg_idx_d;
  logic signed [WGT_W-1:0]   w_q [TAPS];
  logic signed [WGT_W-1:0]   w_d [TAPS];
  logic signed [BIAS_W-1:0]  bias_q,    bias_d;
  logic                      cfg_done_q, cfg_done_d;
  logic [15:0]               drop_q,    drop_d;

  logic                      s1_valid_q, s1_valid_d;
  logic [XW-1:0]             s1_x_q,     s1_x_d;
  logic [YW-1:0]             s1_y_q,     s1_y_d;
  logic signed [PROD_W-1:0]  s1_prod_q [TAPS];
  logic signed [PROD_W-1:0]  s1_prod_d [TAPS];
  logic signed [BIAS_W-1:0]  s1_bias_q,  s1_bias_d;

  logic                      s2_valid_q, s2_valid_d;
  logic [XW-1:0]             s2_x_q,     s2_x_d;
  logic [YW-1:0]             s2_y_q,     s2_y_d;
  logic signed [ROW_W-1:0]   s2_row_q [3];
  logic signed [ROW_W-1:0]   s2_row_d [3];
  logic signed [BIAS_W-1:0]  s2_bias_q,  s2_bias_d;

  logic                      s3_valid_q, s3_valid_d;
  logic [XW-1:0]             s3_x_q,     s3_x_d;
  logic [YW-1:0]             s3_y_q,     s3_y_d;
  logic signed [ACC_W-1:0]   s3_acc_q,   s3_acc_d;

  logic                      out_valid_q, out_valid_d;
  logic [OUT_W-1:0]          out_pixel_q, out_pixel_d;
  logic [XW-1:0]             out_x_q,     out_x_d;
  logic [YW-1:0]             out_y_q,     out_y_d;
  logic                      frame_done_q, frame_done_d;

  logic                      accept;
  logic signed [ACC_W-1:0]   shifted;

  // Config FSM: serial kernel load, any config word while running restarts the load.
  always_comb begin
    state_d    = state_q;
    cfg_idx_d  = cfg_idx_q;
    w_d        = w_q;
    bias_d     = bias_q;
    if (cfg_valid) begin
      case (state_q)
        ST_LOAD: begin
          if (cfg_idx_q == 4'd9) begin
            bias_d    = cfg_data;
            state_d   = ST_RUN;
            cfg_idx_d = 4'd0;
          end else begin
            for (int i = 0; i < TAPS; i++) begin
              if (cfg_idx_q == 4'(i)) w_d[i] = cfg_data[WGT_W-1:0];
            end
            cfg_idx_d = cfg_idx_q + 4'd1;
          end
        end
        ST_RUN: begin
          w_d[0]    = cfg_data[WGT_W-1:0];
          cfg_idx_d = 4'd1;
          state_d   = ST_LOAD;
        end
        default: state_d = ST_LOAD;
      endcase
    end
    cfg_done_d = (state_d == ST_RUN);
  end

  // Acceptance is decided by the state before any same-edge config word takes effect.
  always_comb begin
    accept = win_valid && (state_q == ST_RUN);
    drop_d = drop_q;
    if (win_valid && !accept && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // Datapath: products, row sums, accumulate, then shift/ReLU/saturate.
  always_comb begin
    s1_valid_d = accept;
    s1_x_d     = win_x;
    s1_y_d     = win_y;
    s1_bias_d  = bias_q;
    for (int i = 0; i < TAPS; i++) begin
      s1_prod_d[i] = PROD_W'($signed(win_flat[i*PIX_W +: PIX_W])) * PROD_W'(w_q[i]);
    end

    s2_valid_d = s1_valid_q;
    s2_x_d     = s1_x_q;
    s2_y_d     = s1_y_q;
    s2_bias_d  = s1_bias_q;
    for (int r = 0; r < 3; r++) begin
      s2_row_d[r] = ROW_W'(s1_prod_q[3*r]) + ROW_W'(s1_prod_q[3*r+1]) + ROW_W'(s1_prod_q[3*r+2]);
    end

    s3_valid_d = s2_valid_q;
    s3_x_d     = s2_x_q;
    s3_y_d     = s2_y_q;
    s3_acc_d   = ACC_W'(s2_row_q[0]) + ACC_W'(s2_row_q[1]) + ACC_W'(s2_row_q[2])
               + ACC_W'(s2_bias_q);

    shifted      = s3_acc_q >>> SHIFT;
    out_valid_d  = s3_valid_q;
    out_pixel_d  = out_pixel_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    frame_done_d = 1'b0;
    if (s3_valid_q) begin
      if (shifted[ACC_W-1])        out_pixel_d = '0;
      else if (shifted > PIX_MAX)  out_pixel_d = '1;
      else                         out_pixel_d = OUT_W'(shifted);
      out_x_d      = s3_x_q;
      out_y_d      = s3_y_q;
      frame_done_d = (s3_x_q == XW'(IMG_W - 3)) && (s3_y_q == YW'(IMG_H - 3));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      cfg_idx_q    <= '0;
      bias_q       <= '0;
      cfg_done_q   <= 1'b0;
      drop_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_bias_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      s2_bias_q    <= '0;
      s3_valid_q   <= 1'b0;
      s3_x_q       <= '0;
      s3_y_q       <= '0;
      s3_acc_q     <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        w_q[i]       <= '0;
        s1_prod_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) s2_row_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      cfg_idx_q    <= cfg_idx_d;
      bias_q       <= bias_d;
      cfg_done_q   <= cfg_done_d;
      drop_q       <= drop_d;
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_bias_q    <= s1_bias_d;
      s2_valid_q   <= s2_valid_d;
      s2_x_q       <= s2_x_d;
      s2_y_q       <= s2_y_d;
      s2_bias_q    <= s2_bias_d;
      s3_valid_q   <= s3_valid_d;
      s3_x_q       <= s3_x_d;
      s3_y_q       <= s3_y_d;
      s3_acc_q     <= s3_acc_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < TAPS; i++) begin
        w_q[i]       <= w_d[i];
        s1_prod_q[i] <= s1_prod_d[i];
      end
      for (int r = 0; r < 3; r++) s2_row_q[r] <= s2_row_d[r];
    end
  end

  assign cfg_done   = cfg_done_q;
  assign drop_cnt   = drop_q;
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_relu_pipe.sv
// Randomized bench for conv3x3_relu_pipe against a per-window arithmetic reference model.
module tb_conv3x3_relu_pipe;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int SHIFT = 0;
  localparam int OUT_W = 8;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int MAXV  = (2 ** OUT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic [15:0]       cfg_data;
  logic              cfg_done;
  logic              win_valid;
  logic [80:0]       win_flat;
  logic [XW-1:0]     win_x;
  logic [YW-1:0]     win_y;
  logic              out_valid;
  logic [OUT_W-1:0]  out_pixel;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic              frame_done;
  logic [15:0]       drop_cnt;

  conv3x3_relu_pipe #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WGT_W(8), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_done(cfg_done),
    .win_valid(win_valid), .win_flat(win_flat), .win_x(win_x), .win_y(win_y),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_x(out_x), .out_y(out_y),
    .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int x;
    int y;
    int due;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  // Reference model state
  int   m_w[9];
  int   m_bias;
  bit   m_run;
  int   m_idx;
  int   m_drop;
  int   last_pix, last_x, last_y;

  // Stimulus values
  int   kw[9];
  int   kb;
  int   wp[9];
  int   img[IMG_H][IMG_W];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int conv_ref(input int p[9], input int w[9], input int b);
    int s;
    s = b;
    for (int i = 0; i < 9; i++) s += p[i] * w[i];
    s = s >>> SHIFT;
    if (s < 0) return 0;
    if (s > MAXV) return MAXV;
    return s;
  endfunction

  task automatic model_edge();
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      foreach (m_w[i]) m_w[i] = 0;
      m_bias = 0; m_run = 0; m_idx = 0; m_drop = 0;
      last_pix = 0; last_x = 0; last_y = 0;
      return;
    end
    if (win_valid) begin
      if (m_run) begin
        e.pix = conv_ref(wp, m_w, m_bias);
        e.x = int'(win_x);
        e.y = int'(win_y);
        e.due = cyc + 3;
        exp_q.push_back(e);
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (cfg_valid) begin
      if (m_run) begin
        m_w[0] = int'($signed(cfg_data[7:0]));
        m_idx = 1;
        m_run = 0;
      end else if (m_idx == 9) begin
        m_bias = int'($signed(cfg_data));
        m_run = 1;
        m_idx = 0;
      end else begin
        m_w[m_idx] = int'($signed(cfg_data[7:0]));
        m_idx++;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_pixel", 32'(out_pixel), 32'(e.pix));
      check("out_x", 32'(out_x), 32'(e.x));
      check("out_y", 32'(out_y), 32'(e.y));
      check("frame_done", 32'(frame_done),
            32'((e.x == IMG_W - 3) && (e.y == IMG_H - 3)));
      last_pix = e.pix; last_x = e.x; last_y = e.y;
    end else begin
      check("out_valid_idle", 32'(out_valid), 32'd0);
      check("frame_done_idle", 32'(frame_done), 32'd0);
      check("hold_pixel", 32'(out_pixel), 32'(last_pix));
      check("hold_x", 32'(out_x), 32'(last_x));
      check("hold_y", 32'(out_y), 32'(last_y));
    end
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("cfg_done", 32'(cfg_done), 32'(m_run));
  endtask

  task automatic set_window(input int x, input int y);
    win_x = XW'(x);
    win_y = YW'(y);
    for (int i = 0; i < 9; i++) win_flat[i*9 +: 9] = 9'(wp[i]);
  endtask

  task automatic idle(input int n);
    win_valid = 1'b0;
    cfg_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic cfg_word(input int k);
    cfg_valid = 1'b1;
    cfg_data  = (k < 9) ? 16'(kw[k]) : 16'(kb);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic load_kernel();
    for (int k = 0; k < 10; k++) cfg_word(k);
  endtask

  task automatic send(input int x, input int y);
    set_window(x, y);
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_window();
    for (int i = 0; i < 9; i++) wp[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic rand_kernel();
    for (int i = 0; i < 9; i++) kw[i] = int'($urandom_range(0, 8)) - 4;
    kb = int'($urandom_range(0, 400)) - 100;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    win_valid = 1'b0; win_flat = '0; win_x = '0; win_y = '0;
    tick(); tick();
    rst_n = 1'b1;
    idle(2);

    // Identity kernel
    foreach (kw[i]) kw[i] = 0;
    kw[4] = 1; kb = 0;
    load_kernel();
    rand_window(); wp[4] = 37;
    send(1, 2);
    idle(4);

    // All-ones kernel with negative bias, then ReLU clamp
    foreach (kw[i]) kw[i] = 1;
    kb = -10;
    load_kernel();
    foreach (wp[i]) wp[i] = 10;
    send(0, 0);
    foreach (wp[i]) wp[i] = -10;
    send(5, 5);
    idle(4);

    // Saturation
    foreach (kw[i]) kw[i] = 127;
    kb = 0;
    load_kernel();
    foreach (wp[i]) wp[i] = 255;
    send(3, 3);
    idle(4);

    // Windows during a partial load are dropped
    do_reset();
    rand_kernel();
    for (int k = 0; k < 5; k++) cfg_word(k);
    rand_window(); send(0, 0);
    rand_window(); send(1, 0);
    for (int k = 5; k < 10; k++) cfg_word(k);
    idle(2);

    // Full frame, back-to-back raster windows
    rand_kernel();
    load_kernel();
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) img[y][x] = int'($urandom_range(0, 255));
    win_valid = 1'b1;
    for (int y = 0; y <= IMG_H - 3; y++) begin
      for (int x = 0; x <= IMG_W - 3; x++) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) wp[r*3+c] = img[y+r][x+c];
        set_window(x, y);
        tick();
      end
    end
    win_valid = 1'b0;
    idle(4);

    // Reload while windows stream: same-edge config keeps the old kernel
    rand_kernel();
    win_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      rand_window();
      set_window(k % 6, k / 6);
      if (k >= 2 && k < 12) begin
        cfg_valid = 1'b1;
        cfg_data  = (k - 2 < 9) ? 16'(kw[k-2]) : 16'(kb);
      end else begin
        cfg_valid = 1'b0;
      end
      tick();
    end
    cfg_valid = 1'b0;
    win_valid = 1'b0;
    idle(4);

    // Mid-frame reset drops in-flight work
    win_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_window();
      set_window(k, 1);
      tick();
    end
    win_valid = 1'b0;
    do_reset();
    idle(5);

    // Random traffic with random kernels and gaps
    for (int round = 0; round < 4; round++) begin
      rand_kernel();
      load_kernel();
      for (int k = 0; k < 60; k++) begin
        rand_window();
        set_window(int'($urandom_range(0, IMG_W - 3)), int'($urandom_range(0, IMG_H - 3)));
        win_valid = ($urandom_range(0, 3) != 0);
        cfg_valid = 1'b0;
        tick();
      end
      win_valid = 1'b0;
      idle(4);
    end

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
